// File: rtl/myniosiicpu_cpu_mulx_seq.sv
// Sequential slice multiplier for the mul/mulxss/mulxsu/mulxuu custom instructions.
// Signs are stripped at capture, magnitudes are accumulated one multiplier slice per cycle.
//
// state | meaning
// IDLE  | waiting for A_mul_start; operands captured on accept
// CALC  | one partial product per cycle, N cycles
// FIX   | sign correction and result word select, then done pulse
module myniosiicpu_cpu_mulx_seq #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              A_mul_start,
  input  logic [1:0]        A_mul_mode,
  input  logic [DATA_W-1:0] A_mul_src1,
  input  logic [DATA_W-1:0] A_mul_src2,
  output logic              A_mul_busy,
  output logic              A_mul_done,
  output logic [DATA_W-1:0] A_mul_cell_result
);

  localparam int N     = DATA_W / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PRD_W = DATA_W + SLICE_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [1:0]          mode_q;
  logic                neg_q;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   result_q;
  logic                done_q;

  logic                sign_a;
  logic                sign_b;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [SLICE_W-1:0]  slice;
  logic [PRD_W-1:0]    prod;
  logic [2*DATA_W-1:0] partial;
  logic [2*DATA_W-1:0] res_full;
  logic                last_slice;

  // Unary minus of the most negative value wraps to itself, which is the correct magnitude.
  assign sign_a = A_mul_src1[DATA_W-1] & ((A_mul_mode == 2'b01) | (A_mul_mode == 2'b10));
  assign sign_b = A_mul_src2[DATA_W-1] & (A_mul_mode == 2'b01);
  assign mag_a  = sign_a ? -A_mul_src1 : A_mul_src1;
  assign mag_b  = sign_b ? -A_mul_src2 : A_mul_src2;

  // op_b is shifted right each CALC cycle so the current slice is always its low bits.
  assign slice      = op_b[SLICE_W-1:0];
  assign prod       = PRD_W'(op_a) * PRD_W'(slice);
  assign partial    = (2*DATA_W)'(prod) << (cnt * SLICE_W);
  assign res_full   = neg_q ? -acc : acc;
  assign last_slice = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (A_mul_start) state_nxt = S_CALC;
      S_CALC:  if (last_slice) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    A_mul_busy = (state == S_CALC) || (state == S_FIX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a     <= '0;
      op_b     <= '0;
      mode_q   <= 2'b00;
      neg_q    <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (A_mul_start) begin
            op_a   <= mag_a;
            op_b   <= mag_b;
            mode_q <= A_mul_mode;
            neg_q  <= sign_a ^ sign_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        S_CALC: begin
          acc  <= acc + partial;
          op_b <= op_b >> SLICE_W;
          cnt  <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          result_q <= (mode_q == 2'b00) ? res_full[DATA_W-1:0] : res_full[2*DATA_W-1:DATA_W];
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign A_mul_done        = done_q;
  assign A_mul_cell_result = result_q;

endmodule

// File: tb/tb_myniosiicpu_cpu_mulx_seq.sv
// Scoreboard bench for the sequential multiplier: default 16-bit slices plus an 8-bit slice instance.
module tb_myniosiicpu_cpu_mulx_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] result;

  logic        s8_start;
  logic [1:0]  s8_mode;
  logic [31:0] s8_src1, s8_src2;
  logic        s8_busy, s8_done;
  logic [31:0] s8_result;

  int n_checks = 0;
  int n_errors = 0;
  int model_cnt = 0;
  bit exp_done = 1'b0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  myniosiicpu_cpu_mulx_seq dut (
    .clk(clk), .reset_n(reset_n), .A_mul_start(start), .A_mul_mode(mode),
    .A_mul_src1(src1), .A_mul_src2(src2), .A_mul_busy(busy), .A_mul_done(done),
    .A_mul_cell_result(result)
  );

  myniosiicpu_cpu_mulx_seq #(.DATA_W(32), .SLICE_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .A_mul_start(s8_start), .A_mul_mode(s8_mode),
    .A_mul_src1(s8_src1), .A_mul_src2(s8_src2), .A_mul_busy(s8_busy), .A_mul_done(s8_done),
    .A_mul_cell_result(s8_result)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits and multiply modulo 2^64.
  function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (m == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycle model of the default instance: accept in idle, busy for 3 cycles, then done.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (model_cnt > 0) acc_cnt--;
      model_cnt = 0;
      exp_done  = 1'b0;
      exp_q.delete();
    end else begin
      exp_done = 1'b0;
      if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) exp_done = 1'b1;
      end else if (start) begin
        exp_q.push_back(ref_mul(mode, src1, src2));
        model_cnt = 3;
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check_val("busy", 64'(busy), 64'(model_cnt > 0));
      check_val("done", 64'(done), 64'(exp_done));
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) check_val("sb_nonempty", 64'(exp_q.size()), 64'd1);
        else check_val("sb_result", 64'(result), 64'(exp_q.pop_front()));
      end
    end
  end

  // Caller is at a negedge; start is sampled at the following posedge.
  task automatic do_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input string tag);
    int cyc, bcyc;
    start = 1'b1; mode = m; src1 = a; src2 = b;
    @(negedge clk);
    start = 1'b0; src1 = $urandom; src2 = $urandom; mode = 2'($urandom);
    cyc  = 1;
    bcyc = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
    end
    check_val({tag, "_lat"}, 64'(cyc), 64'd4);
    check_val({tag, "_busycyc"}, 64'(bcyc), 64'd3);
    check_val({tag, "_res"}, 64'(result), 64'(exp_r));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rm;
    int cyc;
    reset_n = 1'b0; start = 1'b0; mode = 2'b00; src1 = '0; src2 = '0;
    s8_start = 1'b0; s8_mode = 2'b00; s8_src1 = '0; s8_src2 = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_res", 64'(result), 64'd0);
    check_val("rst8_busy", 64'(s8_busy), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, "mul_basic");
    @(negedge clk);
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulxuu_ones");
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ones");
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulxss_minneg");
    do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulxss_neg");
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulxsu_ones");
    do_op(2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, "mulxss_zero");
    do_op(2'b10, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "mulxsu_minneg");

    for (int i = 0; i < 12; i++) begin
      rm = 2'($urandom); ra = $urandom; rb = $urandom;
      if (i % 4 == 0) rb = {1'b1, rb[30:0]};
      do_op(rm, ra, rb, ref_mul(rm, ra, rb), "rand");
    end

    // Start held high: only accepts in idle, each gets exactly one done.
    @(negedge clk);
    start = 1'b1; mode = 2'b01; src1 = 32'hFFFF_FFFD; src2 = 32'h0000_0007;
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_val("held_dones", 64'(done_cnt), 64'(acc_cnt));

    // Reset mid-CALC aborts without a done.
    start = 1'b1; mode = 2'b00; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_res", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("abort_nodone", 64'(done_cnt), 64'(acc_cnt));
    do_op(2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, "after_reset");

    // 8-bit slices: 6-cycle latency.
    @(negedge clk);
    s8_start = 1'b1; s8_mode = 2'b00; s8_src1 = 32'h0000_00FF; s8_src2 = 32'h0000_00FF;
    @(negedge clk);
    s8_start = 1'b0; s8_src1 = 32'hDEAD_BEEF; s8_src2 = 32'hCAFE_F00D;
    cyc = 1;
    while (!s8_done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check_val("s8_lat", 64'(cyc), 64'd6);
    check_val("s8_res", 64'(s8_result), 64'h0000_FE01);
    @(negedge clk);
    check_val("s8_done_pulse", 64'(s8_done), 64'd0);

    repeat (2) @(negedge clk);
    check_val("final_dones", 64'(done_cnt), 64'(acc_cnt));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
